// File: rtl/proc_defs.sv
// Shared definitions for the post-halt debug blocks: dump-engine state encoding
// and memory word geometry.
`timescale 1ns/1ps

package proc_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DONE   = 3'd4
    } dump_state_t;

    localparam int WORD_BYTES = 4;

    // Byte address of a word; both operands are already zero-extended to 32 bits.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] index,
                                                   input logic [31:0] stride);
        return index * stride;
    endfunction

endpackage

// File: rtl/mem_dump_engine.sv
// Post-halt memory scanner: reads word addresses 0..WORD_COUNT-1 through the
// muxed memory read port and streams {index, data} to a valid/ready sink.
`timescale 1ns/1ps

// state     | meaning
// ST_IDLE   | waiting for start; outputs quiet, index at 0
// ST_ISSUE  | drive address of current index, arm the read-latency timer
// ST_WAIT   | address held, timer counting down to the read data
// ST_OUTPUT | captured word presented to the sink until accepted
// ST_DONE   | one-cycle completion pulse, then back to idle
module mem_dump_engine
    import proc_defs::*;
#(
    parameter int DATA_W       = 32,
    parameter int WORD_COUNT   = 256,
    parameter int IDX_W        = 8,
    parameter int BYTE_STRIDE  = WORD_BYTES,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_COUNT - 1);
    localparam logic [1:0]       WAIT_LOAD = 2'(READ_LATENCY);

    dump_state_t       state;
    dump_state_t       state_next;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] data_q;
    logic              capture;
    logic              handshake;
    logic              last_word;
    logic [31:0]       idx_addr;

    assign handshake = (state == ST_OUTPUT) && dump_ready;
    assign last_word = (idx == LAST_IDX);
    assign idx_addr  = word_byte_addr(32'(idx), 32'(BYTE_STRIDE));

    // Terminal count is 1, not 0: the data is valid in the cycle the timer
    // leaves 1, so it is captured on that edge as the counter reaches 0.
    assign capture = ((state == ST_ISSUE) && (READ_LATENCY == 0)) ||
                     ((state == ST_WAIT) && (wait_cnt == 2'd1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = (READ_LATENCY == 0) ? ST_OUTPUT : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 2'd1) begin
                    state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (dump_ready) begin
                    state_next = last_word ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= '0;
            wait_cnt <= '0;
            data_q   <= '0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 2'd1;
            end

            if (capture) begin
                data_q <= mem_rd_data;
            end

            // The last index never increments, so idx cannot wrap past WORD_COUNT-1.
            if (handshake && !last_word) begin
                idx <= idx + IDX_W'(1);
            end else if (state == ST_DONE) begin
                idx <= '0;
            end
        end
    end

    // Address is held from ISSUE through OUTPUT so a combinational RD stays stable.
    always_comb begin
        mem_addr   = '0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dump_index = idx;
        dump_data  = data_q;
        unique case (state)
            ST_ISSUE, ST_WAIT: begin
                busy     = 1'b1;
                mem_addr = idx_addr;
            end
            ST_OUTPUT: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                mem_addr   = idx_addr;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Scoreboard bench for mem_dump_engine: three instances (4 words/latency 1,
// 8 words/latency 3, 256 words/latency 0) driven by directed scans.
`timescale 1ns/1ps

module tb_mem_dump_engine;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, ready_a, valid_a, busy_a, done_a;
    logic rst_b, start_b, ready_b, valid_b, busy_b, done_b;
    logic rst_c, start_c, ready_c, valid_c, busy_c, done_c;
    logic [31:0] addr_a, rd_a, data_a;
    logic [31:0] addr_b, rd_b, data_b;
    logic [31:0] addr_c, rd_c, data_c;
    logic [7:0]  idx_a, idx_b, idx_c;
    logic [31:0] pipe_b [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int failures = 0;
    int done_cnt [3] = '{0, 0, 0};
    logic [7:0]  last_idx [3];
    logic [31:0] last_addr [3];

    mem_dump_engine #(.DATA_W(32), .WORD_COUNT(4), .IDX_W(8), .BYTE_STRIDE(4), .READ_LATENCY(1)) u_a (
        .clock(clk), .reset(rst_a), .start(start_a), .mem_addr(addr_a), .mem_rd_data(rd_a),
        .dump_valid(valid_a), .dump_ready(ready_a), .dump_index(idx_a), .dump_data(data_a),
        .busy(busy_a), .done(done_a));

    mem_dump_engine #(.DATA_W(32), .WORD_COUNT(8), .IDX_W(8), .BYTE_STRIDE(4), .READ_LATENCY(3)) u_b (
        .clock(clk), .reset(rst_b), .start(start_b), .mem_addr(addr_b), .mem_rd_data(rd_b),
        .dump_valid(valid_b), .dump_ready(ready_b), .dump_index(idx_b), .dump_data(data_b),
        .busy(busy_b), .done(done_b));

    mem_dump_engine #(.DATA_W(32), .WORD_COUNT(256), .IDX_W(8), .BYTE_STRIDE(4), .READ_LATENCY(0)) u_c (
        .clock(clk), .reset(rst_c), .start(start_c), .mem_addr(addr_c), .mem_rd_data(rd_c),
        .dump_valid(valid_c), .dump_ready(ready_c), .dump_index(idx_c), .dump_data(data_c),
        .busy(busy_c), .done(done_c));

    // Memory contents per instance, addressed by byte address.
    function automatic logic [31:0] mem_word(int k, logic [31:0] addr);
        logic [31:0] w;
        w = addr >> 2;
        case (k)
            0:       return 32'hA000_0000 + w;
            1:       return 32'hB000_0000 + w * 32'h0001_0003;
            default: return 32'hC000_0000 | addr;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_a      <= mem_word(0, addr_a);
        pipe_b[0] <= mem_word(1, addr_b);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rd_b = pipe_b[2];
    assign rd_c = mem_word(2, addr_c);

    // {valid[74], busy[73], done[72], addr[71:40], idx[39:32], data[31:0]}
    function automatic logic [74:0] outs(int k);
        case (k)
            0:       return {valid_a, busy_a, done_a, addr_a, idx_a, data_a};
            1:       return {valid_b, busy_b, done_b, addr_b, idx_b, data_b};
            default: return {valid_c, busy_c, done_c, addr_c, idx_c, data_c};
        endcase
    endfunction

    function automatic logic get_ready(int k);
        case (k)
            0:       return ready_a;
            1:       return ready_b;
            default: return ready_c;
        endcase
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic set_start(int k, logic v);
        case (k)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_ready(int k, logic v);
        case (k)
            0:       ready_a = v;
            1:       ready_b = v;
            default: ready_c = v;
        endcase
    endtask

    task automatic set_rst(int k, logic v);
        case (k)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    task automatic push_words(int k, int first, int count);
        exp_t e;
        for (int i = first; i < first + count; i++) begin
            e.idx  = 8'(i);
            e.data = mem_word(k, 32'(i) * 32'd4);
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic pop_word(int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Leaves the caller 1ns into the first cycle after start was sampled.
    task automatic pulse_start(int k);
        @(posedge clk); #1;
        set_start(k, 1'b1);
        @(posedge clk); #1;
        set_start(k, 1'b0);
    endtask

    task automatic wait_bit(int k, int bit_pos, int limit, input string name, output int n);
        logic [74:0] o;
        n = 1;
        o = outs(k);
        while (!o[bit_pos] && n < limit) begin
            @(posedge clk); #1;
            n++;
            o = outs(k);
        end
        if (!o[bit_pos]) timeout_fail(name);
    endtask

    task automatic handshake_one(int k);
        set_ready(k, 1'b1);
        @(posedge clk); #1;
        set_ready(k, 1'b0);
    endtask

    task automatic mon(int k);
        logic [74:0] o;
        exp_t e;
        o = outs(k);
        if (o[74] && get_ready(k)) begin
            if (qsize(k) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word inst=%0d actual_idx=%0d required=none", k, o[39:32]);
            end else begin
                pop_word(k, e);
                chk($sformatf("word_inst%0d_i%0d", k, e.idx), {o[39:32], o[31:0], o[71:40]},
                    {e.idx, e.data, 32'(e.idx) * 32'd4});
                last_idx[k]  = o[39:32];
                last_addr[k] = o[71:40];
            end
        end
        if (o[72]) begin
            done_cnt[k]++;
            chk($sformatf("done_busy_low_inst%0d", k), {94'd0, o[74], o[73]}, 96'd0);
            chk($sformatf("done_after_words_inst%0d", k), 96'(qsize(k)), 96'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        mon(2);
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        logic [74:0] o;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs_inst%0d", k), 96'(outs(k)), 96'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Basic scan, ready tied high
        set_ready(0, 1'b1);
        push_words(0, 0, 4);
        pulse_start(0);
        o = outs(0);
        chk("a_busy_after_start", 96'(o[73]), 96'd1);
        wait_bit(0, 74, 10, "a_first_valid", n);
        chk("a_first_latency", 96'(n), 96'd3);
        wait_bit(0, 72, 40, "a_done", m);
        chk("a_done_cycle", 96'(n + m - 1), 96'd13);
        @(posedge clk); #1;
        o = outs(0);
        chk("a_done_one_cycle", 96'(o[74:72]), 96'd0);
        chk("a_done_count_scan1", 96'(done_cnt[0]), 96'd1);
        chk("a_last_addr", 96'(last_addr[0]), 96'd12);

        // Backpressure on word 2
        set_ready(0, 1'b0);
        push_words(0, 0, 4);
        pulse_start(0);
        for (int w = 0; w < 4; w++) begin
            wait_bit(0, 74, 10, "a_bp_valid", n);
            if (w == 2) begin
                for (int s = 0; s < 10; s++) begin
                    o = outs(0);
                    chk("a_stall_hold", {o[74], o[73], o[71:40], o[39:32], o[31:0]},
                        {1'b1, 1'b1, 32'd8, 8'd2, 32'hA000_0002});
                    @(posedge clk); #1;
                end
            end
            handshake_one(0);
        end
        wait_bit(0, 72, 10, "a_bp_done", m);
        @(posedge clk); #1;
        chk("a_done_count_bp", 96'(done_cnt[0]), 96'd2);

        // start during scan and during DONE is ignored
        set_ready(0, 1'b1);
        push_words(0, 0, 4);
        pulse_start(0);
        repeat (3) @(posedge clk);
        #1;
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        wait_bit(0, 72, 40, "a_ign_done", m);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        o = outs(0);
        chk("a_start_ignored_idle", 96'(o[74:73]), 96'd0);
        chk("a_done_count_ign", 96'(done_cnt[0]), 96'd3);
        set_ready(0, 1'b0);

        // Reset on word 3 of 8, together with a start
        push_words(1, 0, 3);
        pulse_start(1);
        for (int w = 0; w < 3; w++) begin
            wait_bit(1, 74, 20, "b_valid", n);
            handshake_one(1);
        end
        wait_bit(1, 74, 20, "b_word3_valid", n);
        o = outs(1);
        chk("b_word3_shown", 96'(o[39:32]), 96'd3);
        set_rst(1, 1'b1);
        set_start(1, 1'b1);
        @(posedge clk); #1;
        chk("b_reset_clears", 96'(outs(1)), 96'd0);
        set_rst(1, 1'b0);
        set_start(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        o = outs(1);
        chk("b_start_with_reset_ignored", 96'(o[74:72]), 96'd0);
        chk("b_no_done_after_reset", 96'(done_cnt[1]), 96'd0);

        // Restart after reset, read latency 3
        set_ready(1, 1'b1);
        push_words(1, 0, 8);
        pulse_start(1);
        wait_bit(1, 74, 20, "b_first_valid", n);
        chk("b_first_latency", 96'(n), 96'd5);
        wait_bit(1, 72, 80, "b_done", m);
        chk("b_done_cycle", 96'(n + m - 1), 96'd41);
        @(posedge clk); #1;
        chk("b_done_count", 96'(done_cnt[1]), 96'd1);

        // Full 256-word scan, read latency 0
        set_ready(2, 1'b1);
        push_words(2, 0, 256);
        pulse_start(2);
        wait_bit(2, 74, 10, "c_first_valid", n);
        chk("c_first_latency", 96'(n), 96'd2);
        wait_bit(2, 72, 600, "c_done", m);
        chk("c_done_cycle", 96'(n + m - 1), 96'd513);
        @(posedge clk); #1;
        chk("c_done_count", 96'(done_cnt[2]), 96'd1);
        chk("c_last_index", 96'(last_idx[2]), 96'hFF);
        chk("c_last_addr", 96'(last_addr[2]), 96'd1020);

        for (int k = 0; k < 3; k++) chk($sformatf("queue_empty_inst%0d", k), 96'(qsize(k)), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
